// File: rtl/trigger_capture_if.sv
// -----------------------------------------------------------------------------
// trigger_capture_if
// Bundles the trigger, poll handshake and snapshot read-out signals of
// trigger_capture. Clock and reset stay plain ports on the modules.
//
//   trig_in     user -> capture   one-cycle trigger pulses, one bit per source
//   poll_req    host -> capture   request snapshot + clear (honoured in IDLE)
//   poll_done   host -> capture   host finished reading, releases HOLD
//   poll_ack    capture -> host   snapshot valid and stable
//   poll_flags  capture -> host   snapshot sticky flags
//   cnt_sel     host -> capture   selects snapshot counter for cnt_out
//   cnt_out     capture -> host   selected snapshot count (0 when out of range)
//   overrun     capture -> host   snapshot contained a saturated counter
//   live_any    capture -> host   events pending since the last snapshot
//
// master: the host/user side driving the block; slave: trigger_capture.
// -----------------------------------------------------------------------------
interface trigger_capture_if #(
    parameter int N  = 16,
    parameter int CW = 4,
    parameter int SW = 4
);
    logic [N-1:0]  trig_in;
    logic          poll_req;
    logic          poll_done;
    logic          poll_ack;
    logic [N-1:0]  poll_flags;
    logic [SW-1:0] cnt_sel;
    logic [CW-1:0] cnt_out;
    logic          overrun;
    logic          live_any;

    modport master (
        output trig_in, poll_req, poll_done, cnt_sel,
        input  poll_ack, poll_flags, cnt_out, overrun, live_any
    );

    modport slave (
        input  trig_in, poll_req, poll_done, cnt_sel,
        output poll_ack, poll_flags, cnt_out, overrun, live_any
    );
endinterface

// File: rtl/trigger_capture.sv
// -----------------------------------------------------------------------------
// trigger_capture
// Collects one-cycle trigger pulses into sticky per-bit flags and saturating
// per-bit occurrence counters. A poll request atomically snapshots and clears
// the live set, then the snapshot is held stable until the host signals it is
// done reading.
//
// Ports:
//   clk      single clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      trigger_capture_if.slave (triggers, poll handshake, read-out)
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no snapshot being read; poll_req takes snapshot and clears
//   ST_HOLD  | snapshot valid and frozen; poll_ack=1; waits for poll_done
// -----------------------------------------------------------------------------
module trigger_capture #(
    parameter int N  = 16,
    parameter int CW = 4,
    parameter int SW = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    trigger_capture_if.slave   bus
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_HOLD = 1'b1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [0:0]    state_q,       state_d;
    logic [N-1:0]  live_flags_q,  live_flags_d;
    logic [CW-1:0] live_cnt_q [N];
    logic [CW-1:0] live_cnt_d [N];
    logic [N-1:0]  snap_flags_q,  snap_flags_d;
    logic [CW-1:0] snap_cnt_q [N];
    logic [CW-1:0] snap_cnt_d [N];
    logic          overrun_q,     overrun_d;
    logic          live_any_q,    live_any_d;

    logic          snap_take;
    logic [N-1:0]  sat_vec;
    logic [CW-1:0] cnt_out_c;

    assign snap_take = (state_q == ST_IDLE) && bus.poll_req;

    always_comb begin
        state_d      = state_q;
        live_flags_d = live_flags_q;
        live_cnt_d   = live_cnt_q;
        snap_flags_d = snap_flags_q;
        snap_cnt_d   = snap_cnt_q;
        overrun_d    = overrun_q;
        sat_vec      = '0;

        for (int i = 0; i < N; i++) begin
            sat_vec[i] = (live_cnt_q[i] == CNT_MAX);
            if (snap_take) begin
                // A pulse on the snapshot edge opens the new epoch.
                live_flags_d[i] = bus.trig_in[i];
                live_cnt_d[i]   = {{(CW-1){1'b0}}, bus.trig_in[i]};
            end else if (bus.trig_in[i]) begin
                live_flags_d[i] = 1'b1;
                if (!sat_vec[i]) begin
                    live_cnt_d[i] = live_cnt_q[i] + CW'(1);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.poll_req) begin
                    snap_flags_d = live_flags_q;
                    snap_cnt_d   = live_cnt_q;
                    overrun_d    = |sat_vec;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.poll_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        live_any_d = |live_flags_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            live_flags_q <= '0;
            live_cnt_q   <= '{default: '0};
            snap_flags_q <= '0;
            snap_cnt_q   <= '{default: '0};
            overrun_q    <= 1'b0;
            live_any_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_flags_q <= live_flags_d;
            live_cnt_q   <= live_cnt_d;
            snap_flags_q <= snap_flags_d;
            snap_cnt_q   <= snap_cnt_d;
            overrun_q    <= overrun_d;
            live_any_q   <= live_any_d;
        end
    end

    // Loop compare instead of direct indexing keeps out-of-range selects at 0
    // without ever indexing past the counter array.
    always_comb begin
        cnt_out_c = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.cnt_sel == SW'(i)) begin
                cnt_out_c = snap_cnt_q[i];
            end
        end
    end

    assign bus.poll_ack   = (state_q == ST_HOLD);
    assign bus.poll_flags = snap_flags_q;
    assign bus.overrun    = overrun_q;
    assign bus.live_any   = live_any_q;
    assign bus.cnt_out    = cnt_out_c;

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;

    localparam int N    = 16;
    localparam int CW   = 4;
    localparam int SW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic reset_n;

    trigger_capture_if #(.N(N), .CW(CW), .SW(SW)) bus ();

    trigger_capture #(.N(N), .CW(CW), .SW(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: unbounded event counts per epoch; saturation and
    // flags are derived only when a snapshot is taken.
    int m_cnt  [N];
    int m_snap [N];
    bit m_ovr  = 1'b0;
    bit m_hold = 1'b0;

    function automatic bit any_sat();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) if (m_cnt[i] >= CMAX) r = 1'b1;
        return r;
    endfunction

    function automatic bit any_live();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) if (m_cnt[i] > 0) r = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  <= 0;
                m_snap[i] <= 0;
            end
            m_ovr  <= 1'b0;
            m_hold <= 1'b0;
        end else if (!m_hold && bus.poll_req) begin
            for (int i = 0; i < N; i++) begin
                m_snap[i] <= (m_cnt[i] > CMAX) ? CMAX : m_cnt[i];
                m_cnt[i]  <= int'(bus.trig_in[i]);
            end
            m_ovr  <= any_sat();
            m_hold <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) m_cnt[i] <= m_cnt[i] + int'(bus.trig_in[i]);
            if (m_hold && bus.poll_done) m_hold <= 1'b0;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] ef;
            int sel;
            int ec;
            ef = '0;
            for (int i = 0; i < N; i++) ef[i] = (m_snap[i] > 0);
            sel = int'(bus.cnt_sel);
            ec  = (sel < N) ? m_snap[sel] : 0;
            cmp("model poll_ack",   32'(bus.poll_ack),   32'(m_hold));
            cmp("model poll_flags", 32'(bus.poll_flags), 32'(ef));
            cmp("model overrun",    32'(bus.overrun),    32'(m_ovr));
            cmp("model live_any",   32'(bus.live_any),   32'(any_live()));
            cmp("model cnt_out",    32'(bus.cnt_out),    32'(ec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poll();
        bus.poll_req = 1'b1;
        tick();
        bus.poll_req = 1'b0;
    endtask

    task automatic done();
        bus.poll_done = 1'b1;
        tick();
        bus.poll_done = 1'b0;
    endtask

    task automatic read_cnt(input int sel, input int exp, input string nm);
        bus.cnt_sel = SW'(sel);
        #1;
        cmp(nm, 32'(bus.cnt_out), 32'(exp));
    endtask

    initial begin
        logic [N-1:0] hot;
        reset_n       = 1'b0;
        bus.trig_in   = '0;
        bus.poll_req  = 1'b0;
        bus.poll_done = 1'b0;
        bus.cnt_sel   = '0;

        // Reset with random activity on the inputs
        for (int c = 0; c < 3; c++) begin
            bus.trig_in   = 16'($urandom);
            bus.poll_req  = 1'($urandom);
            bus.poll_done = 1'($urandom);
            tick();
            chk_en = 1'b1;
        end
        reset_n = 1'b1;
        bus.trig_in = '0; bus.poll_req = 1'b0; bus.poll_done = 1'b0;
        tick();
        cmp("rst poll_ack",   32'(bus.poll_ack),   32'd0);
        cmp("rst poll_flags", 32'(bus.poll_flags), 32'd0);
        cmp("rst overrun",    32'(bus.overrun),    32'd0);
        cmp("rst live_any",   32'(bus.live_any),   32'd0);
        poll();
        cmp("rst poll ack",   32'(bus.poll_ack),   32'd1);
        cmp("rst poll flags", 32'(bus.poll_flags), 32'd0);
        cmp("rst poll ovr",   32'(bus.overrun),    32'd0);
        done();

        // Counting
        bus.trig_in = 16'h0021; tick();
        bus.trig_in = 16'h0001; tick();
        tick();
        bus.trig_in = '0;
        cmp("cnt live_any", 32'(bus.live_any), 32'd1);
        poll();
        cmp("cnt ack",   32'(bus.poll_ack),   32'd1);
        cmp("cnt flags", 32'(bus.poll_flags), 32'h0021);
        read_cnt(0, 3,  "cnt sel0");
        read_cnt(5, 1,  "cnt sel5");
        read_cnt(15, 0, "cnt sel15");
        done();
        cmp("cnt ack after done", 32'(bus.poll_ack), 32'd0);

        // Saturation
        bus.trig_in = 16'h0004;
        for (int c = 0; c < 20; c++) tick();
        bus.trig_in = '0;
        poll();
        read_cnt(2, 15, "sat cnt2");
        cmp("sat overrun", 32'(bus.overrun), 32'd1);
        done();
        poll();
        cmp("sat2 flags",   32'(bus.poll_flags), 32'd0);
        cmp("sat2 overrun", 32'(bus.overrun),    32'd0);
        done();

        // Pulse on the snapshot edge belongs to the next epoch
        bus.trig_in = 16'h0002;
        poll();
        bus.trig_in = '0;
        cmp("edge flags1", 32'(bus.poll_flags[1]), 32'd0);
        cmp("edge live_any", 32'(bus.live_any), 32'd1);
        done();
        poll();
        cmp("edge2 flags", 32'(bus.poll_flags), 32'h0002);
        read_cnt(1, 1, "edge2 cnt1");
        done();

        // HOLD stability
        poll();
        bus.trig_in = 16'h0008; tick();
        bus.trig_in = '0;       tick();
        bus.trig_in = 16'h0008;
        poll();
        bus.trig_in = '0;
        cmp("hold ack",   32'(bus.poll_ack),   32'd1);
        cmp("hold flags", 32'(bus.poll_flags), 32'd0);
        done();
        poll();
        cmp("hold2 flags", 32'(bus.poll_flags), 32'h0008);
        read_cnt(3, 2, "hold2 cnt3");
        done();

        // Reset while holding
        bus.trig_in = 16'h0001; tick();
        bus.trig_in = '0;
        poll();
        cmp("mid ack before", 32'(bus.poll_ack), 32'd1);
        reset_n = 1'b0;
        bus.trig_in = 16'h0080;
        tick();
        reset_n = 1'b1;
        cmp("mid ack",   32'(bus.poll_ack),   32'd0);
        cmp("mid flags", 32'(bus.poll_flags), 32'd0);
        bus.trig_in = 16'h0200; tick();
        bus.trig_in = '0;
        poll();
        cmp("mid2 flags", 32'(bus.poll_flags), 32'h0200);
        read_cnt(9, 1, "mid2 cnt9");
        done();

        // Randomized traffic against the model
        hot = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) hot = 16'(1 << $urandom_range(0, N - 1));
            else if ($urandom_range(0, 49) == 0) hot = '0;
            reset_n       = ($urandom_range(0, 399) != 0);
            bus.trig_in   = hot | 16'($urandom & $urandom & $urandom);
            bus.poll_req  = ($urandom_range(0, (c < 2000) ? 7 : 31) == 0);
            bus.poll_done = ($urandom_range(0, 3) == 0);
            bus.cnt_sel   = SW'($urandom_range(0, (1 << SW) - 1));
            tick();
        end
        reset_n = 1'b1;
        bus.trig_in = '0; bus.poll_req = 1'b0; bus.poll_done = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Single-clock event collector for trigger pulses that user logic raises toward the host, such as counter-equals-value flags. It latches one-cycle `trig_in` pulses into sticky per-bit flags and saturating per-bit occurrence counters. On request it atomically snapshots and clears them, then holds the snapshot stable while the host-side logic reads it out. It sits between user logic and the host-interface endpoints.

## Interface
Parameters:
- `N`, 16: number of trigger inputs (1..16).
- `CW`, 4: width of each per-bit occurrence counter (2..8).
- `SW`, 4: width of `cnt_sel`; must satisfy 2^SW >= N.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `trig_in`  in  N  trigger pulses; each high cycle of bit i is one event on bit i.
- `poll_req`  in  1  request snapshot+clear; honoured only in IDLE.
- `poll_done`  in  1  host finished reading; releases HOLD.
- `poll_ack`  out  1  high while in HOLD (snapshot valid and stable).
- `poll_flags`  out  N  snapshot sticky flags; bit i = at least one event on i during the epoch.
- `cnt_sel`  in  SW  selects snapshot counter for `cnt_out`.
- `cnt_out`  out  CW  snapshot count of bit `cnt_sel` (combinational from snapshot regs); 0 if `cnt_sel` >= N.
- `overrun`  out  1  snapshot had at least one counter saturated.
- `live_any`  out  1  registered OR of live flags (events pending since last snapshot).

## Operation
- Registers: live flags L[N], live counters C[i] (CW bits each), snapshot flags S[N], snapshot counters SC[i], state.
- Live accumulation, every cycle in any state: if `trig_in[i]`=1, set L[i]=1 and C[i]=C[i]+1, saturating at 2^CW-1. A held-high input counts once per cycle.
- Per-bit saturation is sticky: once C[i] reaches 2^CW-1 it holds until cleared by a snapshot.
- States: IDLE, HOLD.
  - IDLE -> HOLD on `poll_req`=1. On the same edge: S<=L, SC<=C, `overrun`<=OR over i of (C[i]==2^CW-1), then live clear.
  - Live clear: L[i]<=`trig_in[i]` and C[i]<=`trig_in[i]` (0 or 1). A pulse coinciding with the snapshot edge belongs to the new epoch, so no event is lost or double-counted.
  - HOLD -> IDLE on `poll_done`=1. S, SC and `overrun` keep their values after leaving HOLD until the next snapshot.
  - In HOLD, `poll_req` is ignored with no side effects and live accumulation continues. In IDLE, `poll_done` is ignored.
  - Simultaneous `poll_req` and `poll_done` act per the current state: IDLE snapshots, HOLD releases.
- Width rules: counters are unsigned and never wrap; `cnt_sel` out-of-range reads 0.
- Reset values (`reset_n`=0 at an edge): state IDLE; `poll_ack`=0, `poll_flags`=0, `overrun`=0, `live_any`=0; all L, C, S, SC = 0. Reset overrides all inputs, including `trig_in` and `poll_req` on the same edge, and aborts HOLD immediately.

## Timing
- `poll_req` sampled high at edge t (IDLE): `poll_ack`=1, `poll_flags` and `overrun` valid from just after t. Latency is 1 edge.
- `poll_done` sampled at edge u (HOLD): `poll_ack`=0 just after u. The next `poll_req` is accepted from edge u+1.
- Minimum poll cycle is 2 edges: req, then done.
- `cnt_out` follows `cnt_sel` combinationally, with no wait cycle.
- `live_any` reflects L after each edge. It drops to 0 after a snapshot edge only if no `trig_in` bit was high on that edge.

## Test plan
- Reset: drive random inputs with `reset_n`=0 for 3 cycles, then release -> all outputs 0, `poll_ack`=0. Then a `poll_req` pulse -> `poll_flags`=0, `overrun`=0.
- Counting: pulse `trig_in[0]` 3 times and `trig_in[5]` once, then `poll_req` -> `poll_ack`=1 next cycle, `poll_flags`=16'h0021, `cnt_sel`=0 gives 3, `cnt_sel`=5 gives 1, `cnt_sel`=15 gives 0.
- Saturation: hold `trig_in[2]` high 20 cycles (CW=4), then poll -> count reads 15, `overrun`=1. A second poll with no events -> `poll_flags`=0, `overrun`=0.
- Boundary epoch: pulse `trig_in[1]` on the same edge as `poll_req` -> snapshot bit1=0. A `poll_done` and a second poll -> bit1=1, count=1.
- HOLD stability: during HOLD, pulse `trig_in[3]` twice and issue `poll_req` -> snapshot unchanged, `poll_ack` stays 1. After `poll_done` and a new poll -> count[3]=2.
- Reset mid-HOLD: drive `reset_n`=0 for one cycle while `poll_ack`=1 -> `poll_ack`=0 and snapshot cleared next edge. A fresh poll returns only post-reset events.
